// File: rtl/div_share_arbiter_if.sv
// Requester-side and divider-side handshake bundle for div_share_arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface div_share_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_mode;
    logic [16*NUM_REQ-1:0] req_divisor;
    logic [32*NUM_REQ-1:0] req_dividend;

    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_result;
    logic                  rsp_dz;

    logic                  div_valid_in;
    logic                  div_mode;
    logic [15:0]           div_divisor;
    logic [31:0]           div_dividend;
    logic                  div_valid_out;
    logic [31:0]           div_result;

    modport slave (
        input  req_valid, req_mode, req_divisor, req_dividend,
        input  div_valid_out, div_result,
        output req_ready, rsp_valid, rsp_result, rsp_dz,
        output div_valid_in, div_mode, div_divisor, div_dividend
    );

    modport master (
        output req_valid, req_mode, req_divisor, req_dividend,
        output div_valid_out, div_result,
        input  req_ready, rsp_valid, rsp_result, rsp_dz,
        input  div_valid_in, div_mode, div_divisor, div_dividend
    );
endinterface

// File: rtl/div_share_arbiter.sv
// Round-robin share of one divide/modulo datapath among NUM_REQ requesters.
// Latency: accept -> issue 1 cycle, response D+2 cycles after accept (1 with DIV_ZERO_BYPASS_EN zero divisor).
// Backpressure: req_ready only in IDLE; one op in flight, requesters hold until granted.
module div_share_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                clk,
    input  logic                reset,
    div_share_arbiter_if.slave  bus,
    output logic                busy
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic               op_mode;
    logic [15:0]        op_divisor;
    logic [31:0]        op_dividend;
    logic [31:0]        result_q;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_any;
    logic               accept;
    logic               bypass;

    logic               sel_mode;
    logic [15:0]        sel_divisor;
    logic [31:0]        sel_dividend;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int step);
        int s;
        s = int'(base) + step;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && bus.req_valid[wrap_idx(rr_ptr, k)]) begin
                grant_any = 1'b1;
                grant_idx = wrap_idx(rr_ptr, k);
            end
        end
        grant = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    assign sel_mode     = bus.req_mode[grant_idx];
    assign sel_divisor  = bus.req_divisor[16*grant_idx +: 16];
    assign sel_dividend = bus.req_dividend[32*grant_idx +: 32];

    assign accept = (state == IDLE) && grant_any && !reset;

`ifdef DIV_ZERO_BYPASS_EN
    assign bypass = (sel_divisor == 16'd0);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        state_nxt        = state;
        bus.req_ready    = '0;
        bus.rsp_valid    = '0;
        bus.div_valid_in = 1'b0;
        busy             = 1'b0;

        case (state)
            IDLE: begin
                if (!reset) bus.req_ready = grant;
                if (accept) state_nxt = bypass ? RESP : ISSUE;
            end
            ISSUE: begin
                bus.div_valid_in = !reset;
                busy             = !reset;
                state_nxt        = WAIT;
            end
            WAIT: begin
                busy = !reset;
                if (bus.div_valid_out) state_nxt = RESP;
            end
            RESP: begin
                busy = !reset;
                if (!reset) bus.rsp_valid = NUM_REQ'(1) << owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            op_mode     <= 1'b0;
            op_divisor  <= '0;
            op_dividend <= '0;
            result_q    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_mode     <= sel_mode;
                op_divisor  <= sel_divisor;
                op_dividend <= sel_dividend;
                owner       <= grant_idx;
                rr_ptr      <= wrap_idx(grant_idx, 1);
            end
            if (state == WAIT && bus.div_valid_out) begin
                result_q <= bus.div_result;
            end
            // Zero-divisor shortcut answers without touching the divider.
            if (accept && bypass) begin
                result_q <= sel_mode ? sel_dividend : 32'hFFFF_FFFF;
            end
        end
    end

`ifdef DIV_ZERO_BYPASS_EN
    logic dz_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            dz_q <= 1'b0;
        end else if (accept && bypass) begin
            dz_q <= 1'b1;
        end else if (state == WAIT && bus.div_valid_out) begin
            dz_q <= 1'b0;
        end
    end

    assign bus.rsp_dz = dz_q;
`else
    assign bus.rsp_dz = 1'b0;
`endif

    assign bus.rsp_result   = result_q;
    assign bus.div_mode     = op_mode;
    assign bus.div_divisor  = op_divisor;
    assign bus.div_dividend = op_dividend;

    a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
    a_issue_single: assert property (@(posedge clk) disable iff (reset) bus.div_valid_in |=> !bus.div_valid_in);
    a_rsp_onehot:   assert property (@(posedge clk) disable iff (reset) $onehot0(bus.rsp_valid));

endmodule

// File: tb/tb_div_share_arbiter.sv
// Randomized scoreboard bench for div_share_arbiter with a latency-D divider responder.
module tb_div_share_arbiter;
    localparam int N = 2;
    localparam int D = 5;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    always #5 clk = ~clk;

    div_share_arbiter_if #(.NUM_REQ(N)) bus ();

    div_share_arbiter #(.NUM_REQ(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    typedef struct {
        int          owner;
        logic        mode;
        logic [15:0] dvs;
        logic [31:0] dvd;
        logic [31:0] result;
        logic        dz;
        int          rsp_cyc;
    } exp_t;

    exp_t        sb[$];
    int          acc_owner[$];
    int          acc_cyc[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          issue_due = -1;
    int          mptr = 0;
    int          dvi_cnt = 0;
    int          last_owner = -1;
    logic [31:0] last_res = '0;
    logic [N-1:0] acc_flag = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Divider behaviour: quotient/remainder; all-ones/dividend on zero divisor.
    function automatic logic [31:0] div_ref(input logic mode, input logic [31:0] dvd, input logic [15:0] dvs);
        if (dvs == 16'd0) return mode ? dvd : 32'hFFFF_FFFF;
        return mode ? (dvd % {16'h0, dvs}) : (dvd / {16'h0, dvs});
    endfunction

    function automatic int model_winner(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // Divider responder: answers D cycles after div_valid_in, plus stray pulses when idle.
    initial begin
        int          cnt;
        logic [31:0] res;
        cnt = 0;
        res = '0;
        bus.div_valid_out = 1'b0;
        bus.div_result    = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.div_valid_out = 1'b0;
            if (reset) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.div_valid_out = 1'b1;
                    bus.div_result    = res;
                end
            end else if (bus.div_valid_in) begin
                res = div_ref(bus.div_mode, bus.div_dividend, bus.div_divisor);
                cnt = D;
            end else if ($urandom_range(0, 5) == 0) begin
                bus.div_valid_out = 1'b1;
                bus.div_result    = $urandom;
            end
        end
    end

    // Monitor: checks outputs against the scoreboard, then records accepts.
    always @(negedge clk) begin : monitor
        exp_t         e;
        int           w;
        logic         was_busy;
        logic         byp;
        logic [N-1:0] exp_rv;
        if (reset) begin
            sb.delete();
            issue_due = -1;
            mptr      = 0;
            last_res  = '0;
        end else begin
            was_busy = (sb.size() != 0);
            chk("busy", busy, was_busy);
            chk("div_valid_in", bus.div_valid_in, cyc == issue_due);
            if (bus.div_valid_in) begin
                dvi_cnt++;
                if (was_busy) begin
                    chk("div_mode", bus.div_mode, sb[0].mode);
                    chk("div_divisor", bus.div_divisor, sb[0].dvs);
                    chk("div_dividend", bus.div_dividend, sb[0].dvd);
                end
            end
            exp_rv = '0;
            if (was_busy && sb[0].rsp_cyc == cyc) exp_rv = N'(1) << sb[0].owner;
            chk("rsp_valid", bus.rsp_valid, exp_rv);
            if (exp_rv != '0) begin
                e = sb.pop_front();
                chk("rsp_result", bus.rsp_result, e.result);
                chk("rsp_dz", bus.rsp_dz, e.dz);
                last_res   = e.result;
                last_owner = e.owner;
            end else begin
                chk("rsp_result_hold", bus.rsp_result, last_res);
            end

            w = was_busy ? -1 : model_winner(bus.req_valid, mptr);
            chk("req_ready", bus.req_ready, (w < 0) ? '0 : (N'(1) << w));
            if (w >= 0) begin
                e.owner = w;
                e.mode  = bus.req_mode[w];
                e.dvs   = bus.req_divisor[16*w +: 16];
                e.dvd   = bus.req_dividend[32*w +: 32];
`ifdef DIV_ZERO_BYPASS_EN
                byp = (e.dvs == 16'd0);
`else
                byp = 1'b0;
`endif
                e.result  = div_ref(e.mode, e.dvd, e.dvs);
                e.dz      = byp;
                e.rsp_cyc = cyc + (byp ? 1 : D + 2);
                sb.push_back(e);
                acc_owner.push_back(w);
                acc_cyc.push_back(cyc);
                acc_flag[w] = 1'b1;
                mptr        = (w + 1) % N;
                issue_due   = byp ? -1 : cyc + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_flag[i]) begin
                bus.req_valid[i] = 1'b0;
                acc_flag[i]      = 1'b0;
            end
        end
    endtask

    task automatic load(input int i, input logic mode, input logic [31:0] dvd, input logic [15:0] dvs);
        bus.req_mode[i]             = mode;
        bus.req_dividend[32*i +: 32] = dvd;
        bus.req_divisor[16*i +: 16]  = dvs;
        bus.req_valid[i]            = 1'b1;
    endtask

    task automatic drain(input int budget);
        int b;
        b = 0;
        while ((sb.size() != 0 || bus.req_valid != '0) && b < budget) begin
            tick();
            b++;
        end
        if (b >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d responses outstanding, req_valid %b", sb.size(), bus.req_valid);
        end
    endtask

    function automatic logic [15:0] rand_divisor();
        int          r;
        logic [31:0] x;
        r = $urandom_range(0, 7);
        x = $urandom;
        if (r == 0) return 16'd0;
        if (r == 1) return 16'($urandom_range(1, 15));
        return x[15:0];
    endfunction

    initial begin
        int b;
        int d0;
        reset            = 1'b1;
        bus.req_valid    = '1;
        bus.req_mode     = '0;
        bus.req_divisor  = '0;
        bus.req_dividend = '0;

        repeat (5) begin
            tick();
            chk("rst_req_ready", bus.req_ready, '0);
        end
        chk("rst_rsp_valid", bus.rsp_valid, '0);
        chk("rst_div_valid_in", bus.div_valid_in, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_result", bus.rsp_result, 32'h0);
        chk("rst_rsp_dz", bus.rsp_dz, 1'b0);
        chk("rst_div_dividend", bus.div_dividend, 32'h0);
        chk("rst_div_divisor", bus.div_divisor, 16'h0);
        bus.req_valid = '0;
        reset         = 1'b0;
        tick();

        load(0, 1'b0, 32'h2004_00C0, 16'h6303);
        drain(100);
        chk("dir_quotient", bus.rsp_result, 32'h0000_52C7);
        chk("dir_quotient_owner", last_owner, 0);

        load(1, 1'b1, 32'h2004_00C0, 16'h6303);
        drain(100);
        chk("dir_remainder", bus.rsp_result, 32'h0000_136B);
        chk("dir_remainder_owner", last_owner, 1);
        chk("dir_remainder_dz", bus.rsp_dz, 1'b0);

        acc_owner.delete();
        acc_cyc.delete();
        b = 0;
        while (acc_owner.size() < 4 && b < 200) begin
            for (int i = 0; i < N; i++)
                if (!bus.req_valid[i]) load(i, 1'($urandom_range(0, 1)), $urandom, rand_divisor() | 16'd1);
            tick();
            b++;
        end
        bus.req_valid = '0;
        chk("rr_accepts", acc_owner.size(), 4);
        for (int k = 0; k < acc_owner.size() && k < 4; k++) chk("rr_owner", acc_owner[k], k % 2);
        for (int k = 1; k < acc_cyc.size() && k < 4; k++) chk("rr_gap", acc_cyc[k] - acc_cyc[k-1], D + 3);
        drain(100);

        load(0, 1'b0, $urandom, 16'h0101);
        b = 0;
        while (bus.req_valid[0] && b < 50) begin
            tick();
            b++;
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rsp_valid", bus.rsp_valid, '0);
        chk("midrst_rsp_result", bus.rsp_result, 32'h0);
        repeat (D + 4) tick();
        acc_owner.delete();
        load(0, 1'b1, 32'h0000_0064, 16'h0007);
        load(1, 1'b0, 32'h0000_0064, 16'h0007);
        drain(100);
        chk("post_rst_accepts", acc_owner.size(), 2);
        if (acc_owner.size() > 0) chk("post_rst_first_owner", acc_owner[0], 0);
        chk("post_rst_last_result", bus.rsp_result, 32'd14);

        d0 = dvi_cnt;
`ifdef DIV_ZERO_BYPASS_EN
        load(1, 1'b1, 32'h1234_5678, 16'h0000);
        drain(100);
        chk("zero_bypass_result", bus.rsp_result, 32'h1234_5678);
        chk("zero_bypass_dz", bus.rsp_dz, 1'b1);
        chk("zero_bypass_no_issue", dvi_cnt - d0, 0);
`else
        load(1, 1'b1, 32'h1234_5678, 16'h0000);
        drain(100);
        chk("zero_div_result", bus.rsp_result, 32'h1234_5678);
        chk("zero_div_dz", bus.rsp_dz, 1'b0);
        chk("zero_div_issued", dvi_cnt - d0, 1);
`endif

        repeat (400) begin
            for (int i = 0; i < N; i++)
                if (!bus.req_valid[i] && $urandom_range(0, 2) == 0)
                    load(i, 1'($urandom_range(0, 1)), $urandom, rand_divisor());
            tick();
        end
        drain(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
